// File: rtl/aec_pkg.sv
// aec_pkg
// Shared definitions for the arithmetic expression calculator front-end:
// ASCII character constants, token operator codes, operator-stack entry
// codes, the converter state enum and the operator precedence helpers.
package aec_pkg;

    // ASCII characters recognised by the infix parser
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_A      = 8'h61;
    localparam logic [7:0] CH_F      = 8'h66;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LPAREN = 8'h28;
    localparam logic [7:0] CH_RPAREN = 8'h29;
    localparam logic [7:0] CH_EQ     = 8'h3D;

    // Operator codes carried in tok_val when tok_op=1
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_END = 2'd3;

    // Operator-stack entry codes. The arithmetic operators share their
    // token encoding so a popped entry can be emitted without translation.
    localparam logic [1:0] STK_ADD    = OP_ADD;
    localparam logic [1:0] STK_SUB    = OP_SUB;
    localparam logic [1:0] STK_MUL    = OP_MUL;
    localparam logic [1:0] STK_LPAREN = 2'd3;

    typedef enum logic [2:0] {
        ACCEPT,
        POP_PREC,
        POP_PAREN,
        FLUSH,
        DISCARD,
        END
    } state_e;

    // Binding strength of a stack entry. '(' gets 0 so that an incoming
    // operator never pops past an open parenthesis.
    function automatic logic [1:0] prec(input logic [1:0] code);
        logic [1:0] p;
        case (code)
            STK_MUL:    p = 2'd2;
            STK_LPAREN: p = 2'd0;
            default:    p = 2'd1;
        endcase
        return p;
    endfunction

    // Map an operator character to its stack code (caller guarantees + - *)
    function automatic logic [1:0] op_code(input logic [7:0] ch);
        logic [1:0] c;
        case (ch)
            CH_PLUS:  c = STK_ADD;
            CH_MINUS: c = STK_SUB;
            default:  c = STK_MUL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aec_infix_to_postfix_if.sv
// aec_infix_to_postfix_if
// Groups the character input stream, the token output stream and the busy
// flag of the infix-to-postfix converter.
//   ascii_in/in_valid/in_ready          : character stream into the converter
//   tok_valid/tok_ready/tok_op/tok_val/
//   tok_err                             : token stream to the postfix evaluator
//   busy                                : expression in progress
// modport slave  : the converter's view
// modport master : the view of whoever feeds characters and sinks tokens
interface aec_infix_to_postfix_if;

    logic [7:0] ascii_in;
    logic       in_valid;
    logic       in_ready;
    logic       tok_valid;
    logic       tok_ready;
    logic       tok_op;
    logic [3:0] tok_val;
    logic       tok_err;
    logic       busy;

    modport slave (
        input  ascii_in, in_valid, tok_ready,
        output in_ready, tok_valid, tok_op, tok_val, tok_err, busy
    );

    modport master (
        output ascii_in, in_valid, tok_ready,
        input  in_ready, tok_valid, tok_op, tok_val, tok_err, busy
    );

endinterface

// File: rtl/aec_op_stack.sv
// aec_op_stack
// Parameterised LIFO holding 2-bit operator codes for the shunting-yard
// converter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (empties the stack)
//   push/din : push din when not full
//   pop      : discard the top entry when not empty
//   top      : current top entry (0 when empty)
//   full     : DEPTH entries held
//   empty    : no entries held
module aec_op_stack #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] top,
    output logic       full,
    output logic       empty
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]       mem_q [DEPTH];
    logic [1:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [IDX_W-1:0] top_idx;

    // ptr_q counts entries, so the top lives one slot below it
    assign full    = (ptr_q == PTR_W'(DEPTH));
    assign empty   = (ptr_q == '0);
    assign top_idx = IDX_W'(ptr_q - PTR_W'(1));
    assign top     = empty ? 2'b00 : mem_q[top_idx];

    // Guards on full/empty keep the pointer from ever wrapping even if a
    // caller misbehaves; clear wins over any access in the same cycle.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (push && !full) begin
            mem_d[ptr_q[IDX_W-1:0]] = din;
            ptr_d = ptr_q + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            ptr_q <= ptr_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/aec_infix_to_postfix.sv
// aec_infix_to_postfix
// Converts an ASCII infix expression (hex digits 0-f, + - *, parentheses,
// terminated by '=') into a postfix token stream using a shunting-yard
// operator stack.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : aec_infix_to_postfix_if.slave
//              character input (ascii_in/in_valid/in_ready),
//              token output (tok_valid/tok_ready/tok_op/tok_val/tok_err),
//              busy flag
module aec_infix_to_postfix
    import aec_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int PTR_W       = $clog2(STACK_DEPTH) + 1
) (
    input logic                   clk,
    input logic                   rst,
    aec_infix_to_postfix_if.slave bus
);

    state_e     state_q, state_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic [1:0] pend_op_q, pend_op_d;
    logic       tok_valid_q, tok_valid_d;
    logic       tok_op_q, tok_op_d;
    logic [3:0] tok_val_q, tok_val_d;
    logic       tok_err_q, tok_err_d;

    logic       stk_push, stk_pop, stk_clr;
    logic [1:0] stk_din, stk_top;
    logic       stk_full, stk_empty;

    logic       out_free;
    logic       in_ready;
    logic       accept;
    logic       is_dec, is_hex, is_op;
    logic [3:0] digit_val;

    aec_op_stack #(
        .DEPTH (STACK_DEPTH),
        .PTR_W (PTR_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .clr   (stk_clr),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // The output register can take a new token when it is empty or its
    // current token is being consumed this cycle.
    assign out_free = !tok_valid_q || bus.tok_ready;
    assign in_ready = !rst && (state_q == ACCEPT || state_q == DISCARD) && out_free;
    assign accept   = bus.in_valid && in_ready;

    assign is_dec    = (bus.ascii_in >= CH_0) && (bus.ascii_in <= CH_9);
    assign is_hex    = (bus.ascii_in >= CH_A) && (bus.ascii_in <= CH_F);
    assign is_op     = (bus.ascii_in == CH_PLUS) || (bus.ascii_in == CH_MINUS) ||
                       (bus.ascii_in == CH_STAR);
    assign digit_val = is_dec ? 4'(bus.ascii_in - CH_0)
                              : 4'(bus.ascii_in - CH_A + 8'd10);

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        busy_d      = busy_q;
        pend_op_d   = pend_op_q;
        tok_valid_d = tok_valid_q && !bus.tok_ready;
        tok_op_d    = tok_op_q;
        tok_val_d   = tok_val_q;
        tok_err_d   = tok_err_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_clr     = 1'b0;
        stk_din     = pend_op_q;

        if (accept && !busy_q) begin
            busy_d = 1'b1;
        end

        case (state_q)
            ACCEPT: begin
                // in_ready already guarantees the output register is free
                if (accept) begin
                    if (is_dec || is_hex) begin
                        tok_valid_d = 1'b1;
                        tok_op_d    = 1'b0;
                        tok_val_d   = digit_val;
                        tok_err_d   = 1'b0;
                    end else if (bus.ascii_in == CH_LPAREN) begin
                        if (stk_full) begin
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end else begin
                            stk_push = 1'b1;
                            stk_din  = STK_LPAREN;
                        end
                    end else if (bus.ascii_in == CH_RPAREN) begin
                        state_d = POP_PAREN;
                    end else if (is_op) begin
                        pend_op_d = op_code(bus.ascii_in);
                        state_d   = POP_PREC;
                    end else if (bus.ascii_in == CH_EQ) begin
                        state_d = FLUSH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end

            POP_PREC: begin
                // Left associativity: equal precedence pops too
                if (!stk_empty && (prec(stk_top) >= prec(pend_op_q))) begin
                    if (out_free) begin
                        stk_pop     = 1'b1;
                        tok_valid_d = 1'b1;
                        tok_op_d    = 1'b1;
                        tok_val_d   = {2'b00, stk_top};
                        tok_err_d   = 1'b0;
                    end
                end else if (stk_full) begin
                    err_d   = 1'b1;
                    state_d = DISCARD;
                end else begin
                    stk_push = 1'b1;
                    stk_din  = pend_op_q;
                    state_d  = ACCEPT;
                end
            end

            POP_PAREN: begin
                if (stk_empty) begin
                    err_d   = 1'b1;
                    state_d = DISCARD;
                end else if (stk_top == STK_LPAREN) begin
                    stk_pop = 1'b1;
                    state_d = ACCEPT;
                end else if (out_free) begin
                    stk_pop     = 1'b1;
                    tok_valid_d = 1'b1;
                    tok_op_d    = 1'b1;
                    tok_val_d   = {2'b00, stk_top};
                    tok_err_d   = 1'b0;
                end
            end

            FLUSH: begin
                // An unmatched '(' is dropped silently but marks the error
                if (stk_empty) begin
                    state_d = END;
                end else if (stk_top == STK_LPAREN) begin
                    stk_pop = 1'b1;
                    err_d   = 1'b1;
                end else if (out_free) begin
                    stk_pop     = 1'b1;
                    tok_valid_d = 1'b1;
                    tok_op_d    = 1'b1;
                    tok_val_d   = {2'b00, stk_top};
                    tok_err_d   = 1'b0;
                end
            end

            DISCARD: begin
                if (accept && (bus.ascii_in == CH_EQ)) begin
                    state_d = END;
                end
            end

            END: begin
                if (out_free) begin
                    tok_valid_d = 1'b1;
                    tok_op_d    = 1'b1;
                    tok_val_d   = {2'b00, OP_END};
                    tok_err_d   = err_q;
                    err_d       = 1'b0;
                    stk_clr     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ACCEPT;
                end
            end

            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCEPT;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            pend_op_q   <= OP_ADD;
            tok_valid_q <= 1'b0;
            tok_op_q    <= 1'b0;
            tok_val_q   <= 4'd0;
            tok_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            pend_op_q   <= pend_op_d;
            tok_valid_q <= tok_valid_d;
            tok_op_q    <= tok_op_d;
            tok_val_q   <= tok_val_d;
            tok_err_q   <= tok_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.tok_valid = tok_valid_q;
    assign bus.tok_op    = tok_op_q;
    assign bus.tok_val   = tok_val_q;
    assign bus.tok_err   = tok_err_q;
    assign bus.busy      = busy_q;

endmodule
